// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - initiator-side load/store/fetch controller for a 64 KiB byte memory
//
// Accepts one core request at a time over req_valid/req_ready. Stores are
// issued as a single-cycle write strobe on mem_rw. Loads and fetches drive
// mem_addr, wait RD_WAIT cycles, then sample the 48-bit big-endian window
// and extract/extend it. The response is held on resp_* until resp_ready.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (ready only when idle)
//   req_we, req_size, req_signed       store flag, 00=6B fetch/01=1B/10=2B/11=4B, sign-extend
//   req_addr, req_wdata                byte address, right-aligned store data
//   resp_valid/resp_ready              response handshake
//   resp_rdata, resp_err               extracted load data (0 for stores), illegal-store flag
//   mem_addr, mem_wdata, mem_rw        memory port: 00 = read, 01/10/11 = write 1/2/4 bytes
//   mem_rdata                          memory window, [47:40] = byte at mem_addr
module mem_access_unit #(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [47:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_rw,
    input  logic [47:0] mem_rdata
);

    localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  size_q, size_nxt;
    logic        signed_q, signed_nxt;
    logic [15:0] addr_nxt;
    logic [31:0] wdata_nxt;
    logic [1:0]  rw_nxt;
    logic [47:0] rdata_nxt;
    logic        err_nxt;

    // Window is big-endian: the addressed byte is the most significant one,
    // so narrower loads take the top of the window.
    function automatic logic [47:0] extract(input logic [47:0] w, input logic [1:0] sz,
                                            input logic sx);
        case (sz)
            2'b01:   return {{40{sx & w[47]}}, w[47:40]};
            2'b10:   return {{32{sx & w[47]}}, w[47:32]};
            2'b11:   return {{16{sx & w[47]}}, w[47:16]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 48'd0;
            resp_err   <= 1'b0;
            mem_addr   <= 16'd0;
            mem_wdata  <= 32'd0;
            mem_rw     <= 2'b00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            size_q     <= size_nxt;
            signed_q   <= signed_nxt;
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
            resp_rdata <= rdata_nxt;
            resp_err   <= err_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            mem_rw     <= rw_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        size_nxt   = size_q;
        signed_nxt = signed_q;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        // The write strobe defaults low, so it lasts exactly the WRITE cycle.
        rw_nxt     = 2'b00;
        rdata_nxt  = resp_rdata;
        err_nxt    = resp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    size_nxt   = req_size;
                    signed_nxt = req_signed;
                    if (req_we) begin
                        if (req_size != 2'b00) begin
                            state_nxt = WRITE;
                            addr_nxt  = req_addr;
                            wdata_nxt = req_wdata;
                            rw_nxt    = req_size;
                        end else begin
                            // Store without a byte count: reject, leave memory alone.
                            state_nxt = RESP;
                            rdata_nxt = 48'd0;
                            err_nxt   = 1'b1;
                        end
                    end else begin
                        state_nxt = READ;
                        addr_nxt  = req_addr;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            WRITE: begin
                state_nxt = RESP;
                rdata_nxt = 48'd0;
                err_nxt   = 1'b0;
            end
            READ: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    rdata_nxt = extract(mem_rdata, size_q, signed_q);
                    err_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
